// File: rtl/osd_probe_snapshot.sv
// Per-frame debug probe capture for the hex overlay: each channel snapshots, ORs,
// peaks or counts changes of its probe over a frame and publishes it on vsync.
module osd_probe_snapshot #(
  parameter int C_channels   = 4,
  parameter int C_width      = 16,
  parameter int C_frame_bits = 8
) (
  input  logic                          clk_pixel,
  input  logic                          rst_n,
  input  logic                          i_vsync,
  input  logic [C_channels*C_width-1:0] i_probe,
  input  logic [2*C_channels-1:0]       i_mode,
  input  logic                          i_freeze,
  output logic [C_channels*C_width-1:0] o_display,
  output logic                          o_update,
  output logic [C_frame_bits-1:0]       o_frame
);

  typedef enum logic [1:0] {
    MODE_SNAP  = 2'b00,
    MODE_OR    = 2'b01,
    MODE_PEAK  = 2'b10,
    MODE_COUNT = 2'b11
  } mode_t;

  logic vsync_q;
  logic frame_edge;

  assign frame_edge = i_vsync & ~vsync_q;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      o_update <= 1'b0;
      o_frame  <= '0;
    end else begin
      vsync_q  <= i_vsync;
      o_update <= frame_edge & ~i_freeze;
      if (frame_edge && !i_freeze)
        o_frame <= o_frame + C_frame_bits'(1);
    end
  end

  for (genvar k = 0; k < C_channels; k++) begin : g_ch
    logic [C_width-1:0] probe;
    logic [C_width-1:0] acc;
    logic [C_width-1:0] prev;
    logic [C_width-1:0] result;
    logic [C_width-1:0] disp;
    mode_t              mode;
    mode_t              mode_q;

    assign probe = i_probe[k*C_width +: C_width];
    assign mode  = mode_t'(i_mode[2*k +: 2]);
    assign o_display[k*C_width +: C_width] = disp;

    // Result always uses the live mode, so an edge coinciding with a mode switch
    // publishes under the new mode.
    always_comb begin
      result = probe;
      unique case (mode)
        MODE_SNAP:  result = probe;
        MODE_OR:    result = acc | probe;
        MODE_PEAK:  result = (probe > acc) ? probe : acc;
        MODE_COUNT: begin
          if ((probe != prev) && (acc != '1))
            result = acc + C_width'(1);
          else
            result = acc;
        end
      endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
        acc    <= '0;
        prev   <= '0;
        mode_q <= MODE_SNAP;
        disp   <= '0;
      end else begin
        prev   <= probe;
        mode_q <= mode;
        if (frame_edge || (mode != mode_q))
          acc <= '0;
        else
          acc <= result;
        if (frame_edge && !i_freeze)
          disp <= result;
      end
    end
  end

endmodule

// File: tb/tb_osd_probe_snapshot.sv
// Directed bench for osd_probe_snapshot: expected channel values are queued as
// stimulus is driven and checked when the DUT publishes a frame.
module tb_osd_probe_snapshot;

  logic        clk_pixel = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        freeze;
  logic [15:0] probe_v [4];
  logic [7:0]  mode_v;
  logic [63:0] i_probe;
  logic [63:0] o_display;
  logic        o_update;
  logic [7:0]  o_frame;

  logic [3:0]  probe4;
  logic        vsync4;
  logic [3:0]  display4;
  logic        update4;
  logic [7:0]  frame4;

  typedef struct {
    int          ch;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_compared = 0;
  int          n_failed = 0;
  logic [7:0]  exp_frame = 8'd0;
  logic        pulse_check = 1'b0;
  int          updates;

  assign i_probe = {probe_v[3], probe_v[2], probe_v[1], probe_v[0]};

  always #5 clk_pixel = ~clk_pixel;

  osd_probe_snapshot #(.C_channels(4), .C_width(16), .C_frame_bits(8)) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .i_vsync   (vsync),
    .i_probe   (i_probe),
    .i_mode    (mode_v),
    .i_freeze  (freeze),
    .o_display (o_display),
    .o_update  (o_update),
    .o_frame   (o_frame)
  );

  osd_probe_snapshot #(.C_channels(1), .C_width(4), .C_frame_bits(8)) dut4 (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .i_vsync   (vsync4),
    .i_probe   (probe4),
    .i_mode    (2'b11),
    .i_freeze  (1'b0),
    .o_display (display4),
    .o_update  (update4),
    .o_frame   (frame4)
  );

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (pulse_check) begin
        pulse_check = 1'b0;
        checkOutput("update_one_cycle", o_update, 64'd0);
      end
    end
  endtask

  task automatic pushExpected(input int ch, input logic [15:0] val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic popAndCheck();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput($sformatf("display_ch%0d", e.ch), o_display[e.ch*16 +: 16], e.val);
    end
  endtask

  task automatic frameEdge(input logic frz);
    vsync  = 1'b1;
    freeze = frz;
    tick();
    vsync  = 1'b0;
    freeze = 1'b0;
    if (!frz) begin
      exp_frame++;
      checkOutput("update", o_update, 64'd1);
    end else begin
      checkOutput("update_frozen", o_update, 64'd0);
    end
    popAndCheck();
    checkOutput("frame", o_frame, exp_frame);
    pulse_check = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    vsync  = 1'b0;
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) probe_v[i] = 16'h0000;
    mode_v = 8'b11_10_01_00;
    probe4 = 4'h0;
    vsync4 = 1'b0;

    #2;
    checkOutput("reset_display", o_display, 64'd0);
    checkOutput("reset_update", o_update, 64'd0);
    checkOutput("reset_frame", o_frame, 64'd0);
    checkOutput("reset_display4", display4, 64'd0);
    repeat (2) @(posedge clk_pixel);
    #3;
    rst_n = 1'b1;
    applyStimulus(1);

    // Frame 1: snapshot, sticky-OR, peak and 10 changes together
    for (int i = 0; i < 10; i++) begin
      probe_v[0] = 16'h1234;
      probe_v[1] = (i == 0) ? 16'h0001 : (i == 1) ? 16'h0100 : (i == 2) ? 16'h8000 : 16'h0000;
      probe_v[2] = (i == 0) ? 16'h0005 : (i == 1) ? 16'hFFFE : (i == 2) ? 16'h0003 : 16'h0000;
      probe_v[3] = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      applyStimulus(1);
    end
    probe_v[1] = 16'h0000;
    probe_v[2] = 16'h0000;
    pushExpected(0, 16'h1234);
    pushExpected(1, 16'h8101);
    pushExpected(2, 16'hFFFE);
    pushExpected(3, 16'h000A);
    frameEdge(1'b0);

    // Frame 2: peak channel starts clean
    probe_v[2] = 16'h0007;
    applyStimulus(3);
    pushExpected(0, 16'h1234);
    pushExpected(1, 16'h0000);
    pushExpected(2, 16'h0007);
    pushExpected(3, 16'h0000);
    frameEdge(1'b0);

    // Frozen frame is held and discarded
    probe_v[0] = 16'h5678;
    probe_v[2] = 16'h0100;
    applyStimulus(3);
    pushExpected(0, 16'h1234);
    pushExpected(2, 16'h0007);
    frameEdge(1'b1);
    probe_v[0] = 16'h9ABC;
    probe_v[2] = 16'h0007;
    applyStimulus(3);
    pushExpected(0, 16'h9ABC);
    pushExpected(2, 16'h0007);
    frameEdge(1'b0);

    // Mode switch on ch1 from OR to peak drops the OR history
    probe_v[1] = 16'hFF00;
    applyStimulus(2);
    mode_v[3:2] = 2'b10;
    probe_v[1]  = 16'h0010;
    applyStimulus(3);
    pushExpected(1, 16'h0010);
    frameEdge(1'b0);

    // vsync held high yields a single edge
    applyStimulus(2);
    pushExpected(0, 16'h9ABC);
    pushExpected(1, 16'h0010);
    vsync   = 1'b1;
    updates = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_update) begin
        updates++;
        if (updates == 1) popAndCheck();
      end
    end
    if (updates == 0) sb.delete();
    vsync = 1'b0;
    exp_frame++;
    checkOutput("held_vsync_updates", updates, 64'd1);
    checkOutput("held_vsync_frame", o_frame, exp_frame);
    applyStimulus(2);

    // Frame counter wrap
    for (int i = 0; i < 251; i++) begin
      frameEdge(1'b0);
      applyStimulus(1);
    end
    checkOutput("frame_wrap", o_frame, 64'd0);

    // Async reset between clock edges
    probe_v[1] = 16'hF000;
    applyStimulus(3);
    @(posedge clk_pixel);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_display", o_display, 64'd0);
    checkOutput("async_update", o_update, 64'd0);
    checkOutput("async_frame", o_frame, 64'd0);
    checkOutput("async_display4", display4, 64'd0);
    exp_frame = 8'd0;
    #1;
    rst_n = 1'b1;
    probe_v[1] = 16'h0020;
    applyStimulus(4);
    pushExpected(0, 16'h9ABC);
    pushExpected(1, 16'h0020);
    frameEdge(1'b0);
    applyStimulus(1);

    // Count saturation on the 4-bit instance
    for (int i = 0; i < 40; i++) begin
      probe4 = (i % 2 == 0) ? 4'h1 : 4'h0;
      tick();
    end
    vsync4 = 1'b1;
    tick();
    vsync4 = 1'b0;
    checkOutput("sat_display", display4, 64'hF);
    checkOutput("sat_update", update4, 64'd1);
    checkOutput("sat_frame", frame4, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
